// File: rtl/trafficlight_multiroad_subsm.sv
// Normal-mode sub-state machine for an N-approach intersection.
// Road 0 is the primary rest road; roads 1..N-1 are demand-actuated secondaries
// with latched demand and sensor-driven green extension up to a maximum.
module trafficlight_multiroad_subsm #(
  parameter int unsigned NUM_ROADS         = 4,
  parameter int unsigned TIMER_BITS        = 16,
  parameter int unsigned MIN_GREEN_COUNT   = 5,
  parameter int unsigned MAX_GREEN_COUNT   = 10,
  parameter int unsigned YELLOW_COUNT      = 3,
  parameter int unsigned ALL_RED_COUNT     = 2,
  parameter int unsigned RETURN_TO_PRIMARY = 0
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               ssmIdle,
  input  logic [NUM_ROADS-1:0]               roadSensor,
  output logic [3*NUM_ROADS-1:0]             roadLights_RYG,
  output logic [$clog2(NUM_ROADS)-1:0]       activeRoad,
  output logic [1:0]                         ssmState,
  output logic [NUM_ROADS-1:0]               demand
);

  localparam int unsigned RW = $clog2(NUM_ROADS);

  localparam logic [2:0] LT_RED    = 3'b100;
  localparam logic [2:0] LT_YELLOW = 3'b010;
  localparam logic [2:0] LT_GREEN  = 3'b001;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ALL_RED = 2'd1,
    S_GREEN   = 2'd2,
    S_YELLOW  = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [RW-1:0]            active_q, active_d;
  logic [RW-1:0]            next_q, next_d;
  logic [TIMER_BITS-1:0]    phase_q, phase_d;
  logic [TIMER_BITS-1:0]    max_q, max_d;
  logic [NUM_ROADS-1:0]     demand_q, demand_d;
  logic [3*NUM_ROADS-1:0]   lights_q, lights_d;

  logic                     phase_done;
  logic                     green_exit;
  logic                     scan_found;
  logic [RW-1:0]            scan_road;
  logic [RW-1:0]            scan_idx;
  int unsigned              scan_base;

  assign phase_done = (phase_q == '0);

  // Round-robin search of secondary demand starting just after the active road;
  // a search from road 0 starts at road 1.
  always_comb begin
    scan_found = 1'b0;
    scan_road  = '0;
    scan_idx   = '0;
    scan_base  = (active_q == '0) ? (NUM_ROADS - 1) : 32'(active_q);
    for (int unsigned k = 1; k < NUM_ROADS; k++) begin
      scan_idx = RW'(((scan_base - 1 + k) % (NUM_ROADS - 1)) + 1);
      if (!scan_found && demand_q[scan_idx]) begin
        scan_found = 1'b1;
        scan_road  = scan_idx;
      end
    end
  end

  // Next-state, timer, demand and light computation.
  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    next_d   = next_q;
    phase_d  = phase_done ? '0 : (phase_q - TIMER_BITS'(1));
    max_d    = (max_q == '0) ? '0 : (max_q - TIMER_BITS'(1));
    demand_d = demand_q;
    lights_d = lights_q;

    // Demand latches whenever the road is not currently green.
    for (int unsigned i = 1; i < NUM_ROADS; i++) begin
      if (roadSensor[i] && !(state_q == S_GREEN && active_q == RW'(i))) begin
        demand_d[i] = 1'b1;
      end
    end

    if (active_q == '0) begin
      green_exit = phase_done && (|demand_q[NUM_ROADS-1:1]);
    end else begin
      green_exit = phase_done && (!roadSensor[active_q] || (max_q == '0));
    end

    case (state_q)
      S_IDLE: begin
        if (!ssmIdle) begin
          state_d = S_ALL_RED;
          phase_d = TIMER_BITS'(ALL_RED_COUNT);
          next_d  = '0;
        end
      end
      S_ALL_RED: begin
        if (phase_done) begin
          state_d  = S_GREEN;
          active_d = next_q;
          phase_d  = TIMER_BITS'(MIN_GREEN_COUNT);
          if (next_q != '0) begin
            max_d = TIMER_BITS'(MAX_GREEN_COUNT);
          end
          // Entry clear is applied after the set so it wins on the same edge.
          demand_d[next_q] = 1'b0;
        end
      end
      S_GREEN: begin
        if (green_exit) begin
          state_d = S_YELLOW;
          phase_d = TIMER_BITS'(YELLOW_COUNT);
          if (RETURN_TO_PRIMARY != 0 && active_q != '0) begin
            next_d = '0;
          end else if (scan_found) begin
            next_d = scan_road;
          end else begin
            next_d = '0;
          end
        end
      end
      S_YELLOW: begin
        if (phase_done) begin
          state_d = S_ALL_RED;
          phase_d = TIMER_BITS'(ALL_RED_COUNT);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (ssmIdle) begin
      state_d  = S_IDLE;
      demand_d = '0;
    end

    demand_d[0] = 1'b0;

    // Lights are decoded from the next state so they register alongside it.
    for (int unsigned i = 0; i < NUM_ROADS; i++) begin
      lights_d[3*i +: 3] = LT_RED;
      if (active_d == RW'(i)) begin
        if (state_d == S_GREEN) begin
          lights_d[3*i +: 3] = LT_GREEN;
        end else if (state_d == S_YELLOW) begin
          lights_d[3*i +: 3] = LT_YELLOW;
        end
      end
    end
  end

  // State, timer, demand and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      active_q <= '0;
      next_q   <= '0;
      phase_q  <= TIMER_BITS'(ALL_RED_COUNT);
      max_q    <= TIMER_BITS'(ALL_RED_COUNT);
      demand_q <= '0;
      lights_q <= {NUM_ROADS{LT_RED}};
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      next_q   <= next_d;
      phase_q  <= phase_d;
      max_q    <= max_d;
      demand_q <= demand_d;
      lights_q <= lights_d;
    end
  end

  assign roadLights_RYG = lights_q;
  assign activeRoad     = active_q;
  assign ssmState       = state_q;
  assign demand         = demand_q;

endmodule

// File: tb/tb_trafficlight_multiroad_subsm.sv
// Bench for trafficlight_multiroad_subsm at default parameters, with a second
// instance using forced return to the primary road for the arbitration check.
module tb_trafficlight_multiroad_subsm;

  // Light words for 4 roads, road i at bits [3i+2:3i], RED=100 YELLOW=010 GREEN=001.
  localparam logic [11:0] L_AR = 12'h924;
  localparam logic [11:0] L_G0 = 12'h921;
  localparam logic [11:0] L_Y0 = 12'h922;
  localparam logic [11:0] L_G2 = 12'h864;
  localparam logic [11:0] L_Y2 = 12'h8A4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ssmIdle = 1'b1;
  logic [3:0]  roadSensor = 4'h0;

  logic [11:0] lights_a, lights_b;
  logic [1:0]  active_a, active_b;
  logic [1:0]  state_a, state_b;
  logic [3:0]  demand_a, demand_b;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  trafficlight_multiroad_subsm dut (
    .clk            (clk),
    .reset          (reset),
    .ssmIdle        (ssmIdle),
    .roadSensor     (roadSensor),
    .roadLights_RYG (lights_a),
    .activeRoad     (active_a),
    .ssmState       (state_a),
    .demand         (demand_a)
  );

  trafficlight_multiroad_subsm #(.RETURN_TO_PRIMARY(1)) dut_rtp (
    .clk            (clk),
    .reset          (reset),
    .ssmIdle        (ssmIdle),
    .roadSensor     (roadSensor),
    .roadLights_RYG (lights_b),
    .activeRoad     (active_b),
    .ssmState       (state_b),
    .demand         (demand_b)
  );

  typedef struct {
    logic        rst;
    logic        idle;
    logic [3:0]  sens;
    int unsigned n;
    logic [11:0] lights;
    logic [1:0]  st;
    logic [3:0]  dem;
    logic [1:0]  act;
  } vec_t;

  vec_t vec [12];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_lights(input logic [11:0] tgt, input int unsigned budget, input string nm);
    int unsigned c;
    c = 0;
    while (lights_a !== tgt && c < budget) begin
      tick();
      c++;
    end
    check(nm, 32'(lights_a), 32'(tgt));
  endtask

  task automatic count_green(input logic [11:0] g, input int unsigned rel_at, output int unsigned cnt);
    cnt = 0;
    while (lights_a === g && cnt < 40) begin
      cnt++;
      if (cnt == rel_at) roadSensor = 4'h0;
      tick();
    end
  endtask

  int unsigned cnt;
  logic [1:0]  prev_a, prev_b;
  logic [1:0]  seq_a [$];
  logic [1:0]  seq_b [$];
  logic [1:0]  exp_a [3];
  logic [1:0]  exp_b [4];

  initial begin
    // rst idle sens n lights st dem act
    vec[0]  = '{1'b1, 1'b1, 4'h0,   2, L_AR, 2'd0, 4'h0, 2'd0};
    vec[1]  = '{1'b0, 1'b0, 4'h0,   1, L_AR, 2'd1, 4'h0, 2'd0};
    vec[2]  = '{1'b0, 1'b0, 4'h0,   2, L_AR, 2'd1, 4'h0, 2'd0};
    vec[3]  = '{1'b0, 1'b0, 4'h0, 100, L_G0, 2'd2, 4'h0, 2'd0};
    vec[4]  = '{1'b0, 1'b0, 4'h4,   1, L_G0, 2'd2, 4'h4, 2'd0};
    vec[5]  = '{1'b0, 1'b0, 4'h0,   1, L_Y0, 2'd3, 4'h4, 2'd0};
    vec[6]  = '{1'b0, 1'b0, 4'h0,   3, L_Y0, 2'd3, 4'h4, 2'd0};
    vec[7]  = '{1'b0, 1'b0, 4'h0,   3, L_AR, 2'd1, 4'h4, 2'd0};
    vec[8]  = '{1'b0, 1'b0, 4'h0,   6, L_G2, 2'd2, 4'h0, 2'd2};
    vec[9]  = '{1'b0, 1'b0, 4'h0,   4, L_Y2, 2'd3, 4'h0, 2'd2};
    vec[10] = '{1'b0, 1'b0, 4'h0,   3, L_AR, 2'd1, 4'h0, 2'd2};
    vec[11] = '{1'b0, 1'b0, 4'h0,  10, L_G0, 2'd2, 4'h0, 2'd0};
    exp_a = '{2'd1, 2'd3, 2'd0};
    exp_b = '{2'd1, 2'd0, 2'd3, 2'd0};

    // Reset, start-up and single secondary demand, cycle by cycle.
    for (int r = 0; r < 12; r++) begin
      for (int unsigned c = 0; c < vec[r].n; c++) begin
        reset      = vec[r].rst;
        ssmIdle    = vec[r].idle;
        roadSensor = vec[r].sens;
        tick();
        check($sformatf("row%0d.%0d lights", r, c), 32'(lights_a), 32'(vec[r].lights));
        check($sformatf("row%0d.%0d state",  r, c), 32'(state_a),  32'(vec[r].st));
        check($sformatf("row%0d.%0d demand", r, c), 32'(demand_a), 32'(vec[r].dem));
        check($sformatf("row%0d.%0d active", r, c), 32'(active_a), 32'(vec[r].act));
      end
    end
    roadSensor = 4'h0;

    // Held sensor: green runs to the maximum, 11 cycles.
    roadSensor = 4'h4;
    wait_lights(L_G2, 40, "ext_hold reach G2");
    count_green(L_G2, 0, cnt);
    roadSensor = 4'h0;
    check("ext_hold green len", cnt, 11);
    check("ext_hold yellow", 32'(lights_a), 32'(L_Y2));
    check("ext_hold demand", 32'(demand_a), 32'h0);

    // Release at green cycle 8: yellow on the following edge.
    wait_lights(L_G0, 40, "ext_rel reach G0");
    roadSensor = 4'h4;
    wait_lights(L_G2, 40, "ext_rel reach G2");
    count_green(L_G2, 8, cnt);
    check("ext_rel green len", cnt, 8);
    check("ext_rel yellow", 32'(lights_a), 32'(L_Y2));

    // Simultaneous demands on roads 1 and 3.
    wait_lights(L_G0, 40, "arb reach G0");
    repeat (6) tick();
    roadSensor = 4'b1010;
    tick();
    roadSensor = 4'h0;
    check("arb demand", 32'(demand_a), 32'hA);
    prev_a = state_a;
    prev_b = state_b;
    for (int unsigned c = 0; c < 90; c++) begin
      tick();
      if (state_a == 2'd2 && prev_a != 2'd2) seq_a.push_back(active_a);
      if (state_b == 2'd2 && prev_b != 2'd2) seq_b.push_back(active_b);
      prev_a = state_a;
      prev_b = state_b;
    end
    check("arb rr count", seq_a.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < seq_a.size()) check($sformatf("arb rr green%0d", i), 32'(seq_a[i]), 32'(exp_a[i]));
    end
    check("arb rtp count", seq_b.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < seq_b.size()) check($sformatf("arb rtp green%0d", i), 32'(seq_b[i]), 32'(exp_b[i]));
    end

    // Supervisory hold during road 2 yellow, with a fresh request pending.
    roadSensor = 4'h4;
    tick();
    roadSensor = 4'h0;
    wait_lights(L_Y2, 60, "idle reach Y2");
    ssmIdle    = 1'b1;
    roadSensor = 4'h8;
    tick();
    check("idle lights", 32'(lights_a), 32'(L_AR));
    check("idle state", 32'(state_a), 32'd0);
    check("idle demand", 32'(demand_a), 32'h0);
    check("idle state rtp", 32'(state_b), 32'd0);
    ssmIdle    = 1'b0;
    roadSensor = 4'h0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("resume ar%0d state", c), 32'(state_a), 32'd1);
      check($sformatf("resume ar%0d lights", c), 32'(lights_a), 32'(L_AR));
    end
    tick();
    check("resume green lights", 32'(lights_a), 32'(L_G0));
    check("resume green active", 32'(active_a), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
